pipe_irq_sequencer: RTL and testbench

- Parametrised multi-channel interrupt sequencer for the pipelined processor; successor to the single-line interrupt input of the fetch stage.
- Latches and masks NUM_IRQ interrupt lines and picks one by fixed priority.
- Stalls fetch and drains the pipeline, pushes PC and flags onto the stack through the memory stage, then redirects fetch to a per-channel vector.
- On RTI, pops flags and PC back and resumes. Nested interrupts are not taken.

---
 rtl/pipe_irq_sequencer_pkg.sv | 22 ++
 rtl/pipe_irq_sequencer_priority.sv | 64 ++++++
 rtl/pipe_irq_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_pipe_irq_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_irq_sequencer_pkg.sv
// Shared definitions for the pipelined-processor interrupt sequencer.
//   state_e  : sequencer FSM states (explicit encodings so waveforms and
//              debug taps read the same across builds)
//   calc_idw : width of a channel index, never less than one bit
package pipe_irq_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_PUSH    = 3'd2,
    ST_JUMP    = 3'd3,
    ST_ISR     = 3'd4,
    ST_RDRAIN  = 3'd5,
    ST_POP     = 3'd6,
    ST_RESTORE = 3'd7
  } state_e;

  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_irq_sequencer_priority.sv
// Interrupt front end: rising-edge detection on the irq lines, the pending
// and mask registers, and a fixed-priority encoder (index 0 wins).
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   irq_in         : level interrupt lines
//   mask_wr/_data  : load the mask register (visible the following cycle)
//   take           : the selected channel is being serviced this cycle
//   pending, mask  : register contents
//   eligible_any   : some pending channel is enabled
//   sel_id         : lowest-index pending and enabled channel
module irq_priority_pending
  import pipe_irq_sequencer_pkg::*;
#(
  parameter int                 NUM_IRQ    = 4,
  parameter logic [NUM_IRQ-1:0] MASK_RESET = '1
)(
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_IRQ-1:0]              irq_in,
  input  logic                            mask_wr,
  input  logic [NUM_IRQ-1:0]              mask_data,
  input  logic                            take,
  output logic [NUM_IRQ-1:0]              pending,
  output logic [NUM_IRQ-1:0]              mask,
  output logic                            eligible_any,
  output logic [calc_idw(NUM_IRQ)-1:0]    sel_id
);

  localparam int IDW = calc_idw(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] eligible;

  assign rise     = irq_in & ~irq_q;
  assign eligible = pending & mask;
  assign clr_vec  = take ? (NUM_IRQ'(1) << sel_id) : '0;

  // Walk from the top index down so the lowest eligible index is the
  // last assignment and therefore the winner.
  always_comb begin
    sel_id       = '0;
    eligible_any = |eligible;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (eligible[k]) sel_id = IDW'(k);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= MASK_RESET;
    end else begin
      irq_q   <= irq_in;
      // OR-ing the new edges in after the clear lets a fresh edge survive
      // the cycle in which the same channel is taken.
      pending <= (pending & ~clr_vec) | rise;
      if (mask_wr) mask <= mask_data;
    end
  end

endmodule

// File: rtl/pipe_irq_sequencer.sv
// Multi-channel interrupt sequencer for the pipelined processor.
// On an eligible interrupt it stalls fetch, drains the pipeline, pushes the
// PC (most-significant word first) and the zero-extended flags through the
// memory stage, then loads the channel vector. On RTI it pops flags and the
// PC (least-significant word first) and reloads both. No nesting.
//
// Handshakes: push_valid/push_data are held stable until a cycle in which
// push_ready is high; exactly one word transfers on each rising edge where
// both are high. While pop_req is high, each rising edge with pop_valid high
// delivers exactly one word on pop_data.
//
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   irq_in                : interrupt lines (rising-edge detected)
//   mask_wr, mask_data    : mask register load
//   rti                   : one-cycle RTI pulse from decode
//   pc_current            : PC to save, flags_current : flags to save
//   stall_fetch           : hold PC and fetch buffer
//   flush_decode          : bubble into decode while draining
//   push_valid/data/ready : stack push channel
//   pop_req/data/valid    : stack pop channel
//   pc_load, pc_load_value: fetch redirect pulse and target
//   flags_load, flags_restore : flags reload pulse and value
//   in_isr, active_id     : handler running, channel being serviced
//   pending, mask         : interrupt registers
//   state_dbg             : current FSM state
module pipe_irq_sequencer
  import pipe_irq_sequencer_pkg::*;
#(
  parameter int                  NUM_IRQ       = 4,
  parameter int                  DATA_WIDTH    = 16,
  parameter int                  PC_WIDTH      = 32,
  parameter int                  FLAG_WIDTH    = 3,
  parameter int                  DRAIN_CYCLES  = 3,
  parameter logic [PC_WIDTH-1:0] VECTOR_BASE   = '0,
  parameter int                  VECTOR_STRIDE = 2,
  parameter logic [NUM_IRQ-1:0]  MASK_RESET    = '1
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IRQ-1:0]           irq_in,
  input  logic                         mask_wr,
  input  logic [NUM_IRQ-1:0]           mask_data,
  input  logic                         rti,
  input  logic [PC_WIDTH-1:0]          pc_current,
  input  logic [FLAG_WIDTH-1:0]        flags_current,
  output logic                         stall_fetch,
  output logic                         flush_decode,
  output logic                         push_valid,
  output logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         push_ready,
  output logic                         pop_req,
  input  logic [DATA_WIDTH-1:0]        pop_data,
  input  logic                         pop_valid,
  output logic                         pc_load,
  output logic [PC_WIDTH-1:0]          pc_load_value,
  output logic                         flags_load,
  output logic [FLAG_WIDTH-1:0]        flags_restore,
  output logic                         in_isr,
  output logic [calc_idw(NUM_IRQ)-1:0] active_id,
  output logic [NUM_IRQ-1:0]           pending,
  output logic [NUM_IRQ-1:0]           mask,
  output state_e                       state_dbg
);

  localparam int PC_WORDS = PC_WIDTH / DATA_WIDTH;
  localparam int IDW      = calc_idw(NUM_IRQ);
  localparam int WCW      = $clog2(PC_WORDS + 1);
  localparam int DCW      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e                 state;
  logic [DCW-1:0]         drain_cnt;
  logic [WCW-1:0]         word_cnt;
  logic [PC_WIDTH-1:0]    pc_save;
  logic [FLAG_WIDTH-1:0]  flags_save;
  logic [PC_WIDTH-1:0]    pc_pop;
  logic [FLAG_WIDTH-1:0]  flags_pop;
  logic                   eligible_any;
  logic [IDW-1:0]         sel_id;
  logic                   take;
  logic                   last_word;
  logic                   drain_done;
  int                     push_sel;
  int                     pop_sel;

  assign take       = (state == ST_IDLE) && eligible_any;
  assign last_word  = (word_cnt == WCW'(PC_WORDS));
  assign drain_done = (drain_cnt == DCW'(DRAIN_CYCLES - 1));
  assign state_dbg  = state;

  irq_priority_pending #(
    .NUM_IRQ    (NUM_IRQ),
    .MASK_RESET (MASK_RESET)
  ) u_prio (
    .clk          (clk),
    .reset        (reset),
    .irq_in       (irq_in),
    .mask_wr      (mask_wr),
    .mask_data    (mask_data),
    .take         (take),
    .pending      (pending),
    .mask         (mask),
    .eligible_any (eligible_any),
    .sel_id       (sel_id)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      drain_cnt  <= '0;
      word_cnt   <= '0;
      active_id  <= '0;
      pc_save    <= '0;
      flags_save <= '0;
      pc_pop     <= '0;
      flags_pop  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            active_id  <= sel_id;
            pc_save    <= pc_current;
            flags_save <= flags_current;
            drain_cnt  <= '0;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN, ST_RDRAIN: begin
          if (drain_done) begin
            word_cnt <= '0;
            state    <= (state == ST_DRAIN) ? ST_PUSH : ST_POP;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        ST_PUSH: begin
          if (push_ready) begin
            if (last_word) state <= ST_JUMP;
            else           word_cnt <= word_cnt + WCW'(1);
          end
        end
        ST_JUMP: state <= ST_ISR;
        ST_ISR: begin
          if (rti) begin
            drain_cnt <= '0;
            state     <= ST_RDRAIN;
          end
        end
        ST_POP: begin
          if (pop_valid) begin
            // First word back is the flags; PC words follow low to high.
            if (word_cnt == '0) flags_pop <= pop_data[FLAG_WIDTH-1:0];
            else                pc_pop[pop_sel*DATA_WIDTH +: DATA_WIDTH] <= pop_data;
            if (last_word) state <= ST_RESTORE;
            else           word_cnt <= word_cnt + WCW'(1);
          end
        end
        ST_RESTORE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push_data = '0;
    push_sel  = 0;
    pop_sel   = int'(word_cnt) - 1;
    if (state == ST_PUSH) begin
      if (word_cnt < WCW'(PC_WORDS)) begin
        push_sel  = PC_WORDS - 1 - int'(word_cnt);
        push_data = pc_save[push_sel*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        push_data = DATA_WIDTH'(flags_save);
      end
    end
  end

  always_comb begin
    stall_fetch   = !(state == ST_IDLE || state == ST_JUMP || state == ST_ISR);
    flush_decode  = (state == ST_DRAIN) || (state == ST_RDRAIN);
    push_valid    = (state == ST_PUSH);
    pop_req       = (state == ST_POP);
    in_isr        = (state == ST_ISR);
    pc_load       = (state == ST_JUMP) || (state == ST_RESTORE);
    flags_load    = (state == ST_RESTORE);
    flags_restore = '0;
    pc_load_value = '0;
    if (state == ST_JUMP) begin
      pc_load_value = VECTOR_BASE + PC_WIDTH'(active_id) * PC_WIDTH'(VECTOR_STRIDE);
    end else if (state == ST_RESTORE) begin
      pc_load_value = pc_pop;
      flags_restore = flags_pop;
    end
  end

endmodule

// File: tb/tb_pipe_irq_sequencer.sv
module tb_pipe_irq_sequencer;
  import pipe_irq_sequencer_pkg::*;

  localparam int          NUM_IRQ  = 4;
  localparam int          DW       = 16;
  localparam int          PCW      = 32;
  localparam int          FW       = 3;
  localparam int          PC_WORDS = PCW / DW;
  localparam logic [31:0] VBASE    = 32'h0000_0000;
  localparam int          VSTRIDE  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NUM_IRQ-1:0] irq_in;
  logic               mask_wr;
  logic [NUM_IRQ-1:0] mask_data;
  logic               rti;
  logic [PCW-1:0]     pc_current;
  logic [FW-1:0]      flags_current;
  logic               stall_fetch, flush_decode;
  logic               push_valid;
  logic [DW-1:0]      push_data;
  logic               push_ready;
  logic               pop_req;
  logic [DW-1:0]      pop_data  = '0;
  logic               pop_valid = 1'b0;
  logic               pc_load;
  logic [PCW-1:0]     pc_load_value;
  logic               flags_load;
  logic [FW-1:0]      flags_restore;
  logic               in_isr;
  logic [1:0]         active_id;
  logic [NUM_IRQ-1:0] pending, mask;
  state_e             state_dbg;

  pipe_irq_sequencer #(
    .NUM_IRQ(NUM_IRQ), .DATA_WIDTH(DW), .PC_WIDTH(PCW), .FLAG_WIDTH(FW),
    .DRAIN_CYCLES(3), .VECTOR_BASE(VBASE), .VECTOR_STRIDE(VSTRIDE),
    .MASK_RESET(4'hF)
  ) dut (
    .clk(clk), .reset(rst_n), .irq_in(irq_in), .mask_wr(mask_wr),
    .mask_data(mask_data), .rti(rti), .pc_current(pc_current),
    .flags_current(flags_current), .stall_fetch(stall_fetch),
    .flush_decode(flush_decode), .push_valid(push_valid),
    .push_data(push_data), .push_ready(push_ready), .pop_req(pop_req),
    .pop_data(pop_data), .pop_valid(pop_valid), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .flags_load(flags_load),
    .flags_restore(flags_restore), .in_isr(in_isr), .active_id(active_id),
    .pending(pending), .mask(mask), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [DW-1:0]  exp_push_q[$];
  logic [PCW-1:0] exp_pc_q[$];
  logic [FW-1:0]  exp_flags_q[$];
  logic [DW-1:0]  stack_q[$];
  logic [DW-1:0]  got_push_q[$];
  int             push_count = 0;
  logic [PCW-1:0] model_saved_pc;
  logic [FW-1:0]  model_saved_flags;

  // Transaction model: an interrupt on channel ch saves pc/flags as words
  // (PC high word first, then flags) and redirects to the channel vector.
  task automatic expect_irq(input int ch, input logic [PCW-1:0] pc, input logic [FW-1:0] fl);
    for (int w = PC_WORDS - 1; w >= 0; w--) exp_push_q.push_back(DW'(pc >> (w * DW)));
    exp_push_q.push_back(DW'(fl));
    exp_pc_q.push_back(VBASE + PCW'(ch * VSTRIDE));
    model_saved_pc    = pc;
    model_saved_flags = fl;
  endtask

  // RTI restores exactly what the most recent interrupt saved.
  task automatic expect_rti();
    exp_pc_q.push_back(model_saved_pc);
    exp_flags_q.push_back(model_saved_flags);
  endtask

  // Compare process plus the memory-stage stack (LIFO) responder.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (push_valid) begin
        check("push_stall", stall_fetch, 1);
        if (exp_push_q.size() == 0) check("push_unexpected", 1, 0);
        else begin
          check("push_data", push_data, exp_push_q[0]);
          if (push_ready) begin
            void'(exp_push_q.pop_front());
            got_push_q.push_back(push_data);
            stack_q.push_back(push_data);
            push_count++;
          end
        end
      end
      if (pc_load) begin
        if (exp_pc_q.size() == 0) check("pc_load_unexpected", 1, 0);
        else check("pc_load_value", pc_load_value, exp_pc_q.pop_front());
      end
      if (flags_load) begin
        if (exp_flags_q.size() == 0) check("flags_load_unexpected", 1, 0);
        else check("flags_restore", flags_restore, exp_flags_q.pop_front());
      end
      if (in_isr) check("isr_no_stall", stall_fetch, 0);
      if (pop_req) check("pop_stall", stall_fetch, 1);
    end
    if (rst_n && pop_req && stack_q.size() > 0) begin
      pop_valid = 1'b1;
      pop_data  = stack_q.pop_back();
    end else begin
      pop_valid = 1'b0;
      pop_data  = '0;
    end
  end

  // ---------------- driver tasks ----------------
  // cyc counts the cycle in which the trigger was driven as cycle 1.
  task automatic wait_pc_load(input string name, output int cyc);
    cyc = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      cyc++;
      if (pc_load) return;
    end
    check({name, "_timeout"}, 0, 1);
    cyc = -1;
  endtask

  task automatic wait_state(input state_e s, input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (state_dbg == s) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_rti();
    @(negedge clk);
    expect_rti();
    rti = 1'b1;
    @(negedge clk);
    rti = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int cyc;
  int base_cnt;

  initial begin
    rst_n = 1'b0; irq_in = '0; mask_wr = 1'b0; mask_data = '0; rti = 1'b0;
    pc_current = '0; flags_current = '0; push_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", stall_fetch, 0);
    check("rst_push_valid", push_valid, 0);
    check("rst_pop_req", pop_req, 0);
    check("rst_pc_load", pc_load, 0);
    check("rst_in_isr", in_isr, 0);
    check("rst_active_id", active_id, 0);
    check("rst_pending", pending, 0);
    check("rst_mask", mask, 4'hF);
    check("rst_state", state_dbg, ST_IDLE);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single interrupt on channel 2.
    pc_current = 32'h0001_2345; flags_current = 3'b101;
    expect_irq(2, pc_current, flags_current);
    irq_in[2] = 1'b1;
    wait_pc_load("t1", cyc);
    check("t1_latency", cyc, 9);
    check("t1_vector", pc_load_value, 32'h0000_0004);
    check("t1_active_id", active_id, 2);
    check("t1_pending_clr", pending, 4'b0000);
    check("t1_push_cnt", got_push_q.size(), 3);
    check("t1_word0", got_push_q[0], 16'h0001);
    check("t1_word1", got_push_q[1], 16'h2345);
    check("t1_word2", got_push_q[2], 16'h0005);
    irq_in[2] = 1'b0;
    @(negedge clk); #1;
    check("t1_in_isr", in_isr, 1);
    check("t1_isr_state", state_dbg, ST_ISR);
    pc_current = 32'hDEAD_0000; flags_current = 3'b000;

    // RTI restores the saved PC and flags.
    pulse_rti();
    wait_pc_load("t4", cyc);
    check("t4_flags_load", flags_load, 1);
    check("t4_pc", pc_load_value, 32'h0001_2345);
    check("t4_flags", flags_restore, 3'b101);
    @(negedge clk); #1;
    check("t4_idle", state_dbg, ST_IDLE);
    check("t4_no_stall", stall_fetch, 0);

    // Priority: channels 3 and 1 together, 1 wins, 3 follows after RTI.
    pc_current = 32'hABCD_0010; flags_current = 3'b010;
    expect_irq(1, pc_current, flags_current);
    @(negedge clk); irq_in[3] = 1'b1; irq_in[1] = 1'b1;
    wait_pc_load("t2", cyc);
    check("t2_vector", pc_load_value, 32'h0000_0002);
    check("t2_active_id", active_id, 1);
    check("t2_pending", pending, 4'b1000);
    irq_in = '0;
    pc_current = 32'h0000_7777; flags_current = 3'b011;
    pulse_rti();
    expect_irq(3, 32'h0000_7777, 3'b011);
    wait_pc_load("t2_ret", cyc);
    check("t2_ret_pc", pc_load_value, 32'hABCD_0010);
    check("t2_ret_flags", flags_restore, 3'b010);
    @(negedge clk); #1;
    check("t2_first_idle", state_dbg, ST_IDLE);
    check("t2_still_pending", pending, 4'b1000);
    @(negedge clk); #1;
    check("t2_taken", state_dbg, ST_DRAIN);
    check("t2_pending_clr", pending, 4'b0000);
    check("t2_active3", active_id, 3);
    check("t2_flush", flush_decode, 1);
    wait_pc_load("t2b", cyc);
    check("t2b_vector", pc_load_value, 32'h0000_0006);
    pulse_rti();
    wait_pc_load("t2b_ret", cyc);
    check("t2b_ret_pc", pc_load_value, 32'h0000_7777);

    // Mask: channel 0 disabled stays pending until re-enabled.
    @(negedge clk); mask_wr = 1'b1; mask_data = 4'b1110;
    @(negedge clk); mask_wr = 1'b0;
    #1 check("t3_mask", mask, 4'b1110);
    pc_current = 32'h1234_5678; flags_current = 3'b110;
    irq_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("t3_masked_pending", pending, 4'b0001);
    check("t3_masked_idle", state_dbg, ST_IDLE);
    expect_irq(0, pc_current, flags_current);
    @(negedge clk); mask_wr = 1'b1; mask_data = 4'hF;
    @(negedge clk); mask_wr = 1'b0;
    #1;
    check("t3_mask_on", mask, 4'hF);
    check("t3_not_yet", state_dbg, ST_IDLE);
    @(negedge clk); #1;
    check("t3_taken", state_dbg, ST_DRAIN);
    wait_pc_load("t3", cyc);
    check("t3_vector", pc_load_value, 32'h0000_0000);
    check("t3_active_id", active_id, 0);
    irq_in[0] = 1'b0;
    pulse_rti();
    wait_pc_load("t3_ret", cyc);
    check("t3_ret_pc", pc_load_value, 32'h1234_5678);

    // Backpressure on the second push word.
    @(negedge clk);
    pc_current = 32'h0001_2345; flags_current = 3'b101;
    expect_irq(2, pc_current, flags_current);
    base_cnt = push_count;
    irq_in[2] = 1'b1;
    wait_state(ST_PUSH, "t5_push");
    @(negedge clk); push_ready = 1'b0;
    repeat (3) begin
      #1;
      check("t5_hold_data", push_data, 16'h2345);
      check("t5_hold_valid", push_valid, 1);
      check("t5_hold_stall", stall_fetch, 1);
      @(negedge clk);
    end
    push_ready = 1'b1;
    wait_pc_load("t5", cyc);
    check("t5_vector", pc_load_value, 32'h0000_0004);
    check("t5_word_count", push_count - base_cnt, 3);
    irq_in[2] = 1'b0;
    pulse_rti();
    wait_pc_load("t5_ret", cyc);
    check("t5_ret_pc", pc_load_value, 32'h0001_2345);

    // Reset in the middle of PUSH.
    @(negedge clk); mask_wr = 1'b1; mask_data = 4'b0111;
    @(negedge clk); mask_wr = 1'b0;
    pc_current = 32'hCAFE_F00D; flags_current = 3'b001;
    expect_irq(1, pc_current, flags_current);
    irq_in[1] = 1'b1;
    wait_state(ST_PUSH, "t6_push");
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t6_stall", stall_fetch, 0);
    check("t6_push_valid", push_valid, 0);
    check("t6_push_data", push_data, 0);
    check("t6_pc_load", pc_load, 0);
    check("t6_pc_value", pc_load_value, 0);
    check("t6_active_id", active_id, 0);
    check("t6_pending", pending, 0);
    check("t6_mask", mask, 4'hF);
    check("t6_state", state_dbg, ST_IDLE);
    irq_in = '0;
    exp_push_q.delete(); exp_pc_q.delete(); exp_flags_q.delete(); stack_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("t6_post_idle", state_dbg, ST_IDLE);
    check("t6_post_pending", pending, 0);

    check("end_push_q_empty", exp_push_q.size(), 0);
    check("end_pc_q_empty", exp_pc_q.size(), 0);
    check("end_flags_q_empty", exp_flags_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
